// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: PC register, icache read address, registered IF/ID slot
// with valid/ready handshake, stall and redirect/flush. Optional counters: IFETCH_PERF_EN.
module ifetch_stage #(
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic [ADDR_W-1:0] rdaddr_o,
  input  logic [31:0]       inst_i,
  input  logic              redirect_i,
  input  logic [31:0]       target_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [31:0]       inst_o,
  output logic [31:0]       pc_o,
  output logic [31:0]       pc_plus4_o,
  output logic              misalign_o
`ifdef IFETCH_PERF_EN
  ,
  output logic [15:0]       stall_cnt_o,
  output logic [15:0]       flush_cnt_o
`endif
);

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_q, pc_d;
  logic        misalign_q, misalign_d;
  logic        advance;

  // Handshake: a slot transfers to decode on any edge where valid_o & ready_i.
  // A full slot with ready_i low holds inst_o/pc_o/valid_o exactly; a redirect
  // flushes the slot regardless of ready_i, so the held instruction is dropped.
  assign advance = (state_q == ST_BOOT) || !valid_q || ready_i;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    valid_d    = valid_q;
    inst_d     = inst_q;
    pc_d       = pc_q;
    misalign_d = misalign_q;
    if (redirect_i) begin
      fetch_pc_d = {target_i[31:2], 2'b00};
      valid_d    = 1'b0;
      state_d    = ST_BOOT;
      if (target_i[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
    end else if (advance) begin
      // BOOT refills the empty slot from the freshly loaded PC, then RUN streams.
      valid_d    = 1'b1;
      inst_d     = inst_i;
      pc_d       = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 32'd4;
      state_d    = ST_RUN;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_BOOT;
      fetch_pc_q <= RESET_PC;
      valid_q    <= 1'b0;
      inst_q     <= 32'h0;
      pc_q       <= 32'h0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      valid_q    <= valid_d;
      inst_q     <= inst_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  // Word address wraps within the icache; the PC itself keeps all 32 bits.
  assign rdaddr_o   = fetch_pc_q[ADDR_W+1:2];
  assign valid_o    = valid_q;
  assign inst_o     = inst_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_q + 32'd4;
  assign misalign_o = misalign_q;

`ifdef IFETCH_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((state_q == ST_RUN) && valid_q && !ready_i && !redirect_i &&
        (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (redirect_i && valid_q && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= 16'h0;
      flush_cnt_q <= 16'h0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_ifetch_stage.sv
// Bench for ifetch_stage: table of per-cycle vectors plus hand sequences for
// redirect latency and a ready toggle pattern. Icache word k holds 32'h1000_0000+k.
module tb_ifetch_stage;

  localparam int          AW = 6;
  localparam logic [31:0] W0 = 32'h1000_0000;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [AW-1:0] rdaddr_o;
  logic [31:0]   inst_i;
  logic          redirect_i;
  logic [31:0]   target_i;
  logic          ready_i;
  logic          valid_o;
  logic [31:0]   inst_o;
  logic [31:0]   pc_o;
  logic [31:0]   pc_plus4_o;
  logic          misalign_o;
`ifdef IFETCH_PERF_EN
  logic [15:0]   stall_cnt_o;
  logic [15:0]   flush_cnt_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // clock/reset block
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // icache model: combinational read
  assign inst_i = W0 + {{(32-AW){1'b0}}, rdaddr_o};

  ifetch_stage #(.ADDR_W(AW), .RESET_PC(32'h0000_0000)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rdaddr_o   (rdaddr_o),
    .inst_i     (inst_i),
    .redirect_i (redirect_i),
    .target_i   (target_i),
    .ready_i    (ready_i),
    .valid_o    (valid_o),
    .inst_o     (inst_o),
    .pc_o       (pc_o),
    .pc_plus4_o (pc_plus4_o),
    .misalign_o (misalign_o)
`ifdef IFETCH_PERF_EN
    ,
    .stall_cnt_o(stall_cnt_o),
    .flush_cnt_o(flush_cnt_o)
`endif
  );

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        redir;
    logic [31:0] tgt;
    logic        ev;
    logic [31:0] ei;
    logic [31:0] ep;
    logic [5:0]  ea;
    logic        em;
    logic [15:0] es;
    logic [15:0] ef;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic rdy, logic redir, logic [31:0] tgt,
                              logic ev, logic [31:0] ei, logic [31:0] ep,
                              logic [5:0] ea, logic em, logic [15:0] es, logic [15:0] ef);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.redir = redir; v.tgt = tgt;
    v.ev = ev; v.ei = ei; v.ep = ep; v.ea = ea; v.em = em; v.es = es; v.ef = ef;
    return v;
  endfunction

  // scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic rdy, input logic redir, input logic [31:0] tgt);
    @(negedge clk_i);
    rst_i      = rst;
    ready_i    = rdy;
    redirect_i = redir;
    target_i   = tgt;
  endtask

  int          pat[6] = '{1, 0, 1, 1, 0, 1};
  logic [31:0] exp_pc;
  int          lat;

  initial begin
    rst_i = 1'b1; ready_i = 1'b1; redirect_i = 1'b0; target_i = 32'h0;

    //                rst rdy rd  tgt           ev ei      ep           ea  em  stall flush
    vecs.push_back(mk(1, 1, 0, 32'h0,   0, 32'h0,  32'h0,   6'd0,  0, 0, 0)); // v0 reset
    vecs.push_back(mk(0, 1, 0, 32'h0,   1, W0+0,   32'h0,   6'd1,  0, 0, 0)); // v1 boot
    vecs.push_back(mk(0, 1, 0, 32'h0,   1, W0+1,   32'h4,   6'd2,  0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0,   1, W0+2,   32'h8,   6'd3,  0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,   1, W0+2,   32'h8,   6'd3,  0, 1, 0)); // v4 stall
    vecs.push_back(mk(0, 0, 0, 32'h0,   1, W0+2,   32'h8,   6'd3,  0, 2, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,   1, W0+2,   32'h8,   6'd3,  0, 3, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0,   1, W0+3,   32'hC,   6'd4,  0, 3, 0)); // v7 resume
    vecs.push_back(mk(0, 1, 0, 32'h0,   1, W0+4,   32'h10,  6'd5,  0, 3, 0));
    vecs.push_back(mk(0, 0, 1, 32'h40,  0, 32'h0,  32'h0,   6'd16, 0, 3, 1)); // v9 redirect
    vecs.push_back(mk(0, 0, 0, 32'h0,   1, W0+16,  32'h40,  6'd17, 0, 3, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,   1, W0+16,  32'h40,  6'd17, 0, 4, 1));
    vecs.push_back(mk(0, 1, 0, 32'h0,   1, W0+17,  32'h44,  6'd18, 0, 4, 1));
    vecs.push_back(mk(0, 1, 1, 32'h46,  0, 32'h0,  32'h0,   6'd17, 1, 4, 2)); // v13 misaligned
    vecs.push_back(mk(0, 1, 0, 32'h0,   1, W0+17,  32'h44,  6'd18, 1, 4, 2));
    vecs.push_back(mk(0, 1, 0, 32'h0,   1, W0+18,  32'h48,  6'd19, 1, 4, 2));
    vecs.push_back(mk(0, 1, 1, 32'hF4,  0, 32'h0,  32'h0,   6'd61, 1, 4, 3)); // v16 aligned
    vecs.push_back(mk(0, 1, 0, 32'h0,   1, W0+61,  32'hF4,  6'd62, 1, 4, 3));
    vecs.push_back(mk(0, 1, 0, 32'h0,   1, W0+62,  32'hF8,  6'd63, 1, 4, 3));
    vecs.push_back(mk(0, 1, 0, 32'h0,   1, W0+63,  32'hFC,  6'd0,  1, 4, 3));
    vecs.push_back(mk(0, 1, 0, 32'h0,   1, W0+0,   32'h100, 6'd1,  1, 4, 3)); // v20 wrap
    vecs.push_back(mk(0, 1, 0, 32'h0,   1, W0+1,   32'h104, 6'd2,  1, 4, 3));
    vecs.push_back(mk(0, 0, 0, 32'h0,   1, W0+1,   32'h104, 6'd2,  1, 5, 3)); // v22 stall
    vecs.push_back(mk(1, 0, 0, 32'h0,   0, 32'h0,  32'h0,   6'd0,  0, 0, 0)); // v23 reset
    vecs.push_back(mk(0, 1, 0, 32'h0,   1, W0+0,   32'h0,   6'd1,  0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0,   1, W0+1,   32'h4,   6'd2,  0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].rdy, vecs[i].redir, vecs[i].tgt);
      @(posedge clk_i); #1;
      chk($sformatf("v%0d valid", i), {31'h0, valid_o}, {31'h0, vecs[i].ev});
      chk($sformatf("v%0d rdaddr", i), {26'h0, rdaddr_o}, {26'h0, vecs[i].ea});
      chk($sformatf("v%0d misalign", i), {31'h0, misalign_o}, {31'h0, vecs[i].em});
      if (vecs[i].ev) begin
        chk($sformatf("v%0d inst", i), inst_o, vecs[i].ei);
        chk($sformatf("v%0d pc", i), pc_o, vecs[i].ep);
        chk($sformatf("v%0d pc_plus4", i), pc_plus4_o, vecs[i].ep + 32'd4);
      end
`ifdef IFETCH_PERF_EN
      chk($sformatf("v%0d stall_cnt", i), {16'h0, stall_cnt_o}, {16'h0, vecs[i].es});
      chk($sformatf("v%0d flush_cnt", i), {16'h0, flush_cnt_o}, {16'h0, vecs[i].ef});
`endif
    end

    // redirect latency with ready high: held instruction dropped, target after 2 edges
    drive(1'b0, 1'b1, 1'b1, 32'h80);
    @(posedge clk_i); #1;
    chk("redir_flush valid", {31'h0, valid_o}, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    lat = 1;
    while (!valid_o && lat < 8) begin
      @(posedge clk_i); #1;
      lat++;
    end
    chk("redir_latency", lat, 32'd2);
    chk("redir pc", pc_o, 32'h80);
    chk("redir inst", inst_o, W0 + 32'd32);
    chk("redir misalign", {31'h0, misalign_o}, 32'h0);

    // ready toggle: one instruction per accepted cycle, no skip or duplicate
    exp_pc = 32'h80;
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, pat[k][0], 1'b0, 32'h0);
      @(posedge clk_i); #1;
      if (pat[k] != 0) exp_pc = exp_pc + 32'd4;
      chk($sformatf("tog%0d valid", k), {31'h0, valid_o}, 32'h1);
      chk($sformatf("tog%0d pc", k), pc_o, exp_pc);
      chk($sformatf("tog%0d inst", k), inst_o, W0 + {26'h0, exp_pc[7:2]});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
